// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// Module   : reg_scoreboard_pkg
// Purpose  : Shared widths, constants and helpers for the register scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;

  // Default width of each per-register pending-write counter
  localparam int SB_CNT_W = 2;

  // GPR address width and the hard-wired zero register
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Bus widths: issue = {fire, we, dest}; retire = {we, dest, wdata}
  localparam int SB_ISSUE_BUS_WD  = 1 + 1 + REG_W;
  localparam int SB_RETIRE_BUS_WD = 1 + REG_W + 32;

  // Issue event as seen on the DS->ES handshake
  typedef struct packed {
    logic             fire;
    logic             we;
    logic [REG_W-1:0] dest;
  } sb_issue_t;

  // Register 0 never holds a value, so it is never tracked
  function automatic logic sb_tracked(input logic [REG_W-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_counter.sv
// ============================================================================
// Module   : sb_counter
// Purpose  : One saturating up/down pending-write counter with synchronous
//            clear and an underflow strobe (retire seen while counter is 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Pending count: clear wins; simultaneous inc/dec cancel; saturate at both ends
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // A retire against an empty counter is a bookkeeping error (ignored under clear)
  assign underflow = dec & ~clr & (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register in-flight write tracker driving the decode stall
//            for RAW hazards and for a destination whose counter is full.
//            Optional feature macro: SCOREBOARD_BYPASS_EN (forward WS data to
//            decode when the retiring write is the last one outstanding).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int NREG  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        issue_fire,
  input  logic        issue_we,
  input  logic [4:0]  issue_dest,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_wdata,
  input  logic        ds_valid,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  output logic        ds_stall,
  output logic        rs_fwd,
  output logic        rt_fwd,
  output logic [31:0] rs_fwd_data,
  output logic [31:0] rt_fwd_data,
  output logic [2:0]  inflight_cnt,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_issue_t issue_bus;
  logic      inc;
  logic      dec;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            underflow;

  logic rs_busy, rt_busy;
  logic rs_byp,  rt_byp;
  logic rs_haz,  rt_haz;
  logic dest_full;

  // Qualified issue / retire events; writes to $0 are never tracked
  assign issue_bus = '{fire: issue_fire, we: issue_we, dest: issue_dest};
  assign inc = issue_bus.fire & issue_bus.we & sb_tracked(issue_bus.dest);
  assign dec = wb_we & sb_tracked(wb_dest);

  // Register 0 has no counter
  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (flush),
        .inc       (inc & (issue_dest == REG_W'(r))),
        .dec       (dec & (wb_dest == REG_W'(r))),
        .cnt       (cnt[r]),
        .underflow (underflow[r])
      );
    end
  endgenerate

  // A source is busy while any write to it is outstanding
  assign rs_busy = sb_tracked(rs_addr) & (cnt[rs_addr] != '0);
  assign rt_busy = sb_tracked(rt_addr) & (cnt[rt_addr] != '0);

`ifdef SCOREBOARD_BYPASS_EN
  // The last outstanding write retiring this cycle can be forwarded directly
  assign rs_byp      = wb_we & (wb_dest == rs_addr) & rs_busy & (cnt[rs_addr] == CNT_ONE);
  assign rt_byp      = wb_we & (wb_dest == rt_addr) & rt_busy & (cnt[rt_addr] == CNT_ONE);
  assign rs_fwd      = rs_byp;
  assign rt_fwd      = rt_byp;
  assign rs_fwd_data = wb_wdata;
  assign rt_fwd_data = wb_wdata;
`else
  // Without bypass the decode waits for the regfile write to land
  logic unused_wdata;
  assign unused_wdata = ^wb_wdata;
  assign rs_byp       = 1'b0;
  assign rt_byp       = 1'b0;
  assign rs_fwd       = 1'b0;
  assign rt_fwd       = 1'b0;
  assign rs_fwd_data  = '0;
  assign rt_fwd_data  = '0;
`endif

  // Stall on a RAW hazard or when the decode destination cannot take another write
  assign rs_haz    = rs_used & rs_busy & ~rs_byp;
  assign rt_haz    = rt_used & rt_busy & ~rt_byp;
  assign dest_full = issue_we & (cnt[issue_dest] == CNT_MAX);
  assign ds_stall  = ds_valid & (rs_haz | rt_haz | dest_full);

  // Total outstanding writes, saturating at 7 and never going below 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_cnt <= 3'd0;
    end else if (flush) begin
      inflight_cnt <= 3'd0;
    end else if (inc && !dec) begin
      if (inflight_cnt != 3'd7) inflight_cnt <= inflight_cnt + 3'd1;
    end else if (dec && !inc) begin
      if (inflight_cnt != 3'd0) inflight_cnt <= inflight_cnt - 3'd1;
    end
  end

  // Sticky error: a retire arrived for a register with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_err <= 1'b0;
    end else if (|underflow) begin
      sb_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Self-checking bench for reg_scoreboard: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  localparam int MAXC = 3;  // 2**CNT_W - 1 for CNT_W = 2

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush, issue_fire, issue_we, wb_we, ds_valid, rs_used, rt_used;
  logic [4:0]  issue_dest, wb_dest, rs_addr, rt_addr;
  logic [31:0] wb_wdata;
  logic        ds_stall, rs_fwd, rt_fwd, sb_err;
  logic [31:0] rs_fwd_data, rt_fwd_data;
  logic [2:0]  inflight_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int cnt_m[32];
  int infl_m;
  bit err_m;

  reg_scoreboard dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .issue_fire   (issue_fire),
    .issue_we     (issue_we),
    .issue_dest   (issue_dest),
    .wb_we        (wb_we),
    .wb_dest      (wb_dest),
    .wb_wdata     (wb_wdata),
    .ds_valid     (ds_valid),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .ds_stall     (ds_stall),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .rs_fwd_data  (rs_fwd_data),
    .rt_fwd_data  (rt_fwd_data),
    .inflight_cnt (inflight_cnt),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    infl_m = 0;
    err_m  = 1'b0;
  endtask

  // Can the WS write be forwarded to a source reading register a?
  function automatic bit byp_m(input logic [4:0] a);
`ifdef SCOREBOARD_BYPASS_EN
    return wb_we && (a != 0) && (wb_dest == a) && (cnt_m[a] == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    bit rsf, rtf, rsh, rth, full, st;
    logic [31:0] fdat;
    rsf  = byp_m(rs_addr);
    rtf  = byp_m(rt_addr);
    rsh  = rs_used && (rs_addr != 0) && (cnt_m[rs_addr] > 0) && !rsf;
    rth  = rt_used && (rt_addr != 0) && (cnt_m[rt_addr] > 0) && !rtf;
    full = issue_we && (cnt_m[issue_dest] == MAXC);
    st   = ds_valid && (rsh || rth || full);
`ifdef SCOREBOARD_BYPASS_EN
    fdat = wb_wdata;
`else
    fdat = 32'd0;
`endif
    check({tag, ".stall"},  ds_stall, st);
    check({tag, ".rsfwd"},  rs_fwd, rsf);
    check({tag, ".rtfwd"},  rt_fwd, rtf);
    check({tag, ".rsdat"},  rs_fwd_data, fdat);
    check({tag, ".rtdat"},  rt_fwd_data, fdat);
    check({tag, ".infl"},   inflight_cnt, infl_m);
    check({tag, ".err"},    sb_err, err_m);
  endtask

  // Apply the clock edge to the model using the inputs currently driven
  task automatic model_update();
    bit inc, dec;
    if (!resetn) return;
    if (flush) begin
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
      infl_m = 0;
      return;
    end
    inc = issue_fire && issue_we && (issue_dest != 0);
    dec = wb_we && (wb_dest != 0);
    if (dec && cnt_m[wb_dest] == 0) err_m = 1'b1;
    if (!(inc && dec && issue_dest == wb_dest)) begin
      if (inc && cnt_m[issue_dest] < MAXC) cnt_m[issue_dest]++;
      if (dec && cnt_m[wb_dest] > 0) cnt_m[wb_dest]--;
    end
    if (inc && !dec && infl_m < 7) infl_m++;
    else if (dec && !inc && infl_m > 0) infl_m--;
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; issue_fire = 0; issue_we = 0; issue_dest = 0;
    wb_we = 0; wb_dest = 0; wb_wdata = 0;
    ds_valid = 0; rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
  endtask

  task automatic do_issue(input logic [4:0] d);
    idle(); issue_fire = 1; issue_we = 1; issue_dest = d;
    #1 check_all("issue"); tick();
  endtask

  task automatic do_retire(input logic [4:0] d);
    idle(); wb_we = 1; wb_dest = d; wb_wdata = $urandom;
    #1 check_all("retire"); tick();
  endtask

  initial begin
    idle();
    reset_model();
    // Asynchronous reset takes effect without a clock edge
    #3 resetn = 0;
    #1 check_all("reset");
    @(negedge clk);
    resetn = 1;

    // RAW on $5: stall until retire has updated the counter
    do_issue(5'd5);
    idle(); ds_valid = 1; rs_addr = 5; rs_used = 1;
    #1 check("raw_stall", ds_stall, 1'b1);
    wb_we = 1; wb_dest = 5; wb_wdata = 32'h1234_5678;
    #1 check_all("raw_retire");
    tick();
    wb_we = 0;
    #1 check("raw_release", ds_stall, 1'b0);
    check_all("raw_after");

    // Retire of the only outstanding $5 write while decode reads rt=$5
    do_issue(5'd5);
    idle(); ds_valid = 1; rt_addr = 5; rt_used = 1;
    wb_we = 1; wb_dest = 5; wb_wdata = 32'hDEAD_BEEF;
`ifdef SCOREBOARD_BYPASS_EN
    #1 check("byp_stall", ds_stall, 1'b0);
    check("byp_rtfwd", rt_fwd, 1'b1);
    check("byp_data", rt_fwd_data, 32'hDEAD_BEEF);
`else
    #1 check("nobyp_stall", ds_stall, 1'b1);
    check("nobyp_rtfwd", rt_fwd, 1'b0);
`endif
    check_all("byp");
    tick();

    // Same-cycle issue and retire on $7 leaves its counter at 1
    do_issue(5'd7);
    idle(); issue_fire = 1; issue_we = 1; issue_dest = 7; wb_we = 1; wb_dest = 7;
    #1 check_all("same7");
    tick();
    idle(); ds_valid = 1; rs_addr = 7; rs_used = 1;
    #1 check("same7_stall", ds_stall, 1'b1);
    check("same7_infl", inflight_cnt, 3'd1);
    check_all("same7_after");
    do_retire(5'd7);

    // Three writes fill $9; a fourth writer must stall; $0 is never tracked
    do_issue(5'd9);
    do_issue(5'd9);
    do_issue(5'd9);
    idle(); ds_valid = 1; issue_we = 1; issue_dest = 9;
    #1 check("full9_stall", ds_stall, 1'b1);
    check_all("full9");
    do_issue(5'd0);
    check("zero_infl", inflight_cnt, 3'd3);
    do_retire(5'd9);
    do_retire(5'd9);
    do_retire(5'd9);

    // Underflow on $3 is sticky and survives flush
    do_issue(5'd11);
    do_retire(5'd3);
    check("err_set", sb_err, 1'b1);
    idle();
    tick();
    check("err_sticky", sb_err, 1'b1);
    idle(); flush = 1;
    #1 check_all("flush");
    tick();
    idle();
    #1 check("flush_infl", inflight_cnt, 3'd0);
    check("flush_err", sb_err, 1'b1);
    check_all("post_flush");

    // Randomized traffic with occasional flush and mid-run async reset
    for (int cyc = 0; cyc < 600; cyc++) begin
      int pend[$];
      idle();
      for (int i = 1; i < 32; i++) if (cnt_m[i] > 0) pend.push_back(i);
      issue_fire = ($urandom_range(0, 1) == 1);
      issue_we   = ($urandom_range(0, 3) != 0);
      issue_dest = 5'($urandom_range(0, 7));
      wb_we      = ($urandom_range(0, 2) != 0);
      if (pend.size() > 0 && $urandom_range(0, 7) != 0)
        wb_dest = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wb_dest = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      ds_valid = ($urandom_range(0, 3) != 0);
      rs_addr  = 5'($urandom_range(0, 7));
      rt_addr  = 5'($urandom_range(0, 7));
      rs_used  = $urandom_range(0, 1);
      rt_used  = $urandom_range(0, 1);
      flush    = ($urandom_range(0, 39) == 0);
      #1 check_all("rand");
      if ($urandom_range(0, 79) == 0) begin
        resetn = 0;
        reset_model();
        #1 check_all("arst");
        @(negedge clk);
        resetn = 1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
